uart_tx_fifo: RTL and testbench

- Byte FIFO and issue sequencer sitting directly upstream of the UART transmitter.
- Accepts bytes from the system side with a single-cycle write strobe and buffers up to DEPTH entries.
- Feeds the transmitter one byte at a time using its write-strobe / busy handshake, so producers can burst without tracking line timing.

---
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO plus issue sequencer that sits in front of a UART transmitter.
// System-side producers push bytes with a single-cycle strobe. The sequencer
// hands them to the transmitter one at a time using its write-strobe / busy
// handshake.
//
// Ports
//   i_clk       system clock, all logic on the rising edge
//   i_rst_n     asynchronous active-low reset
//   i_wr        push strobe, one byte per cycle while high
//   i_data      byte to push, sampled when i_wr=1
//   o_full      count == DEPTH
//   o_empty     count == 0
//   o_count     number of bytes currently stored (AW+1 bits)
//   o_overflow  one-cycle pulse after a push was dropped because the FIFO was full
//   i_tx_busy   transmitter busy flag, rises the cycle after it accepts a write
//   o_tx_wr     registered one-cycle write strobe to the transmitter
//   o_tx_data   registered byte to the transmitter, held after the strobe
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH),
  parameter int BUSY_WAIT = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr,
  input  logic [7:0]    i_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  input  logic          i_tx_busy,
  output logic          o_tx_wr,
  output logic [7:0]    o_tx_data
);

  // Wait counter only needs to reach BUSY_WAIT.
  localparam int WW = (BUSY_WAIT < 2) ? 1 : $clog2(BUSY_WAIT + 1);

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(BUSY_WAIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [WW-1:0]   wait_cnt_reg;
  logic [WW-1:0]   wait_cnt_next;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW:0]     count_reg;

  logic            tx_wr_reg;
  logic [7:0]      tx_data_reg;
  logic            overflow_reg;

  logic            is_full;
  logic            push;
  logic            pop;

  // Fullness is judged on the count before the edge, so a push that lands on
  // the same edge as a pop from a full FIFO is still dropped.
  assign is_full = (count_reg == FULL_COUNT);
  assign push    = i_wr && !is_full;

  // ---------------------------------------------------------------------------
  // Issue sequencer: next-state and pop decision
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    pop           = 1'b0;

    case (state_reg)
      IDLE: begin
        if ((count_reg != '0) && !i_tx_busy) begin
          pop           = 1'b1;
          state_next    = WAIT_BUSY;
          wait_cnt_next = '0;
        end
      end

      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_next = WAIT_DONE;
        end else begin
          // A transmitter that never acknowledges is given up on; the byte
          // counts as sent and is not retried.
          wait_cnt_next = wait_cnt_reg + WW'(1);
          if (wait_cnt_next == WAIT_LIMIT) begin
            state_next = IDLE;
          end
        end
      end

      WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, pointers, count and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      tx_wr_reg    <= 1'b0;
      tx_data_reg  <= 8'h00;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      tx_wr_reg    <= pop;
      overflow_reg <= i_wr && is_full;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end

      // Registered read of the head entry straight into the output byte.
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
        tx_data_reg <= mem[rd_ptr_reg];
      end

      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage array carries no reset so it maps onto block/distributed RAM.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  assign o_full     = is_full;
  assign o_empty    = (count_reg == '0);
  assign o_count    = count_reg;
  assign o_overflow = overflow_reg;
  assign o_tx_wr    = tx_wr_reg;
  assign o_tx_data  = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo (DEPTH=4). A queue-based reference model
// runs on the rising edge from the bench-driven inputs; a monitor on the
// falling edge compares every DUT output against it and checks each
// transmitted byte against a scoreboard of accepted pushes.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH     = 4;
  localparam int AW        = 2;
  localparam int BUSY_WAIT = 3;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          wr      = 1'b0;
  logic [7:0]    data    = 8'h00;
  logic          tx_busy = 1'b0;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          tx_wr;
  logic [7:0]    tx_data;

  uart_tx_fifo #(
    .DEPTH     (DEPTH),
    .BUSY_WAIT (BUSY_WAIT)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr       (wr),
    .i_data     (data),
    .o_full     (full),
    .o_empty    (empty),
    .o_count    (count),
    .o_overflow (overflow),
    .i_tx_busy  (tx_busy),
    .o_tx_wr    (tx_wr),
    .o_tx_data  (tx_data)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: FIFO contents as a queue, sequencer as "free / waiting for
  // busy with a deadline / waiting for busy to drop".
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] gen;
    logic [7:0]  b;
  } sb_t;

  logic [7:0] fifo_q[$];
  sb_t        sb_q[$];
  int         gen       = 0;
  bit         seq_busy  = 1'b0;
  bit         got_busy  = 1'b0;
  int         wait_left = 0;
  bit         exp_wr    = 1'b0;
  bit         exp_ovf   = 1'b0;
  bit         m_issue;
  bit         m_full;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      fifo_q.delete();
      seq_busy = 1'b0;
      got_busy = 1'b0;
      exp_wr   = 1'b0;
      exp_ovf  = 1'b0;
      gen++;
    end else begin
      m_issue = !seq_busy && (fifo_q.size() > 0) && !tx_busy;
      m_full  = (fifo_q.size() == DEPTH);
      if (seq_busy) begin
        if (!got_busy) begin
          if (tx_busy) begin
            got_busy = 1'b1;
          end else begin
            wait_left--;
            if (wait_left == 0) seq_busy = 1'b0;
          end
        end else if (!tx_busy) begin
          seq_busy = 1'b0;
        end
      end
      if (m_issue) begin
        void'(fifo_q.pop_front());
        seq_busy  = 1'b1;
        got_busy  = 1'b0;
        wait_left = BUSY_WAIT;
      end
      exp_ovf = wr && m_full;
      if (wr && !m_full) begin
        fifo_q.push_back(data);
        sb_q.push_back('{gen: gen, b: data});
      end
      exp_wr = m_issue;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor (falling edge) followed by the transmitter model.
  // ---------------------------------------------------------------------------
  bit         prev_wr   = 1'b0;
  logic [7:0] last_data = 8'h00;
  sb_t        mon_e;
  int         busy_cnt  = 0;
  bit         pending   = 1'b0;
  bit         busy_hold = 1'b0;
  bit         tx_ignore = 1'b0;
  int         busy_len  = 4;

  initial forever begin
    @(negedge clk);
    check("count",    32'(count),    32'(fifo_q.size()));
    check("full",     32'(full),     32'(fifo_q.size() == DEPTH));
    check("empty",    32'(empty),    32'(fifo_q.size() == 0));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("tx_wr",    32'(tx_wr),    32'(exp_wr));
    if (tx_wr) begin
      check("busy_at_pulse", 32'(tx_busy), 32'(0));
      check("pulse_gap",     32'(prev_wr), 32'(0));
      while (sb_q.size() > 0 && sb_q[0].gen != 32'(gen)) void'(sb_q.pop_front());
      if (sb_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL tx_unexpected: got byte 0x%0h, expected no transmission", tx_data);
      end else begin
        mon_e     = sb_q.pop_front();
        last_data = mon_e.b;
      end
    end
    if (!rst_n) last_data = 8'h00;
    check("tx_data", 32'(tx_data), 32'(last_data));
    prev_wr = tx_wr;

    if (busy_cnt > 0) busy_cnt--;
    if (pending) begin
      pending  = 1'b0;
      busy_cnt = busy_len;
    end
    if (tx_wr && !tx_ignore) pending = 1'b1;
    tx_busy = busy_hold || (busy_cnt > 0);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic push(input logic [7:0] b);
    wr   = 1'b1;
    data = b;
    @(negedge clk);
    wr   = 1'b0;
    $display("[TB] push 0x%02h count=%0d overflow=%0b", b, count, overflow);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(fifo_q.size() == 0 && !seq_busy && !tx_busy && busy_cnt == 0 && !pending) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      failed++;
      $display("FAIL idle_timeout: still busy after %0d cycles, expected drained", n);
    end
    repeat (2) @(negedge clk);
  endtask

  int outstanding;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_wr",    32'(tx_wr),    32'(0));
    check("rst_tx_data",  32'(tx_data),  32'(8'h00));
    check("rst_count",    32'(count),    32'(0));
    check("rst_empty",    32'(empty),    32'(1));
    check("rst_full",     32'(full),     32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: strobe two edges after the push edge
    push(8'hA5);
    @(negedge clk);
    check("single_wr",   32'(tx_wr),   32'(1));
    check("single_data", 32'(tx_data), 32'(8'hA5));
    wait_idle();
    check("single_count", 32'(count), 32'(0));
    check("single_empty", 32'(empty), 32'(1));

    // Burst of three with a slow transmitter
    busy_len = 10;
    wr = 1'b1; data = 8'h01; @(negedge clk);
    data = 8'h02; @(negedge clk);
    data = 8'h03; @(negedge clk);
    wr = 1'b0;
    wait_idle();

    // Fill with the transmitter held busy, then overflow
    @(posedge clk); #1 busy_hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) push(8'h20 + 8'(i));
    check("fill_full",  32'(full),  32'(1));
    check("fill_count", 32'(count), 32'(DEPTH));
    push(8'hFF);
    check("fill_overflow", 32'(overflow), 32'(1));

    // Push on the issue edge while full: dropped, count goes to DEPTH-1
    @(posedge clk); #1 busy_hold = 1'b0;
    @(negedge clk);
    push(8'hEE);
    check("pushpop_overflow", 32'(overflow), 32'(1));
    check("pushpop_count",    32'(count),    32'(DEPTH - 1));
    busy_len = 3;
    wait_idle();

    // Wrap-around: ten bytes paced so the FIFO never overflows
    busy_len = 2;
    for (int k = 0; k < 10; k++) begin
      for (int n = 0; n < 200 && fifo_q.size() >= DEPTH; n++) @(negedge clk);
      push(8'h10 + 8'(k));
    end
    wait_idle();

    // Reset mid-burst while waiting for the transmitter to finish
    busy_len = 20;
    wr = 1'b1; data = 8'h30; @(negedge clk);
    data = 8'h31; @(negedge clk);
    data = 8'h32; @(negedge clk);
    data = 8'h33; @(negedge clk);
    wr = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_queued", 32'(count), 32'(3));
    @(posedge clk); #2 busy_hold = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_wr",    32'(tx_wr),    32'(0));
    check("midrst_tx_data",  32'(tx_data),  32'(8'h00));
    check("midrst_count",    32'(count),    32'(0));
    check("midrst_empty",    32'(empty),    32'(1));
    check("midrst_full",     32'(full),     32'(0));
    check("midrst_overflow", 32'(overflow), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push(8'h55);
    repeat (6) @(negedge clk);
    check("postrst_held", 32'(count), 32'(1));
    @(posedge clk); #1 busy_hold = 1'b0;
    wait_idle();
    check("postrst_empty", 32'(empty), 32'(1));

    // Busy timeout: transmitter never raises busy
    tx_ignore = 1'b1;
    wr = 1'b1; data = 8'h40; @(negedge clk);
    data = 8'h41; @(negedge clk);
    wr = 1'b0;
    check("timeout_first", 32'(tx_wr), 32'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("timeout_next", 32'(tx_wr), 32'(i == 3));
    end
    wait_idle();
    tx_ignore = 1'b0;

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      wr   = ($urandom_range(0, 2) != 0);
      data = 8'($urandom);
      if ($urandom_range(0, 15) == 0) busy_len  = $urandom_range(0, 6);
      if ($urandom_range(0, 31) == 0) tx_ignore = ~tx_ignore;
      @(negedge clk);
      if (tx_wr) $display("[TB] tx 0x%02h count=%0d", tx_data, count);
    end
    wr = 1'b0;
    tx_ignore = 1'b0;
    busy_len  = 3;
    wait_idle();

    outstanding = 0;
    foreach (sb_q[i]) if (sb_q[i].gen == 32'(gen)) outstanding++;
    check("all_sent", 32'(outstanding), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
